// File: rtl/infer_sequencer_if.sv
// Handshake bundle between the grid source, the MLP and the result display.
// The sequencer connects through the slave modport; the grid/MLP side uses master.
interface infer_sequencer_if;
  logic        grid_valid;
  logic [15:0] grid_in;
  logic        mlp_start;
  logic [15:0] mlp_grid;
  logic        mlp_done;
  logic        mlp_class;
  logic        result_valid;
  logic        result_class;
  logic        busy;
  logic        timeout_err;
  logic        overrun;

  modport master (
    output grid_valid, grid_in, mlp_done, mlp_class,
    input  mlp_start, mlp_grid, result_valid, result_class, busy, timeout_err, overrun
  );

  modport slave (
    input  grid_valid, grid_in, mlp_done, mlp_class,
    output mlp_start, mlp_grid, result_valid, result_class, busy, timeout_err, overrun
  );
endinterface

// File: rtl/infer_sequencer.sv
// Sequences one MLP inference per submitted 4x4 grid and holds the result on display.
// All outputs are flops whose next values are derived from the next FSM state.
module infer_sequencer #(
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned SHOW_CYCLES = 1000
) (
  input logic              clk,
  input logic              rst,
  infer_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, SHOW} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] mlp_grid_q, mlp_grid_d;
  logic        mlp_start_q, mlp_start_d;
  logic        result_valid_q, result_valid_d;
  logic        result_class_q, result_class_d;
  logic        busy_q, busy_d;
  logic        timeout_err_q, timeout_err_d;
  logic        overrun_q, overrun_d;
  logic        grid_ok;

  assign grid_ok = bus.grid_valid && (bus.grid_in != 16'd0);

  // One counter serves both WAIT (timeout) and SHOW (display time); each exit clears it.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mlp_grid_d     = mlp_grid_q;
    result_class_d = result_class_q;
    timeout_err_d  = timeout_err_q;
    overrun_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grid_ok) begin
          mlp_grid_d    = bus.grid_in;
          timeout_err_d = 1'b0;
          state_d       = START;
        end
      end
      START: begin
        overrun_d = bus.grid_valid;
        cnt_d     = 32'd0;
        state_d   = WAIT;
      end
      WAIT: begin
        overrun_d = bus.grid_valid;
        if (bus.mlp_done) begin
          result_class_d = bus.mlp_class;
          cnt_d          = 32'd0;
          state_d        = SHOW;
        end else if (cnt_q == 32'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          cnt_d         = 32'd0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SHOW: begin
        if (grid_ok) begin
          mlp_grid_d    = bus.grid_in;
          timeout_err_d = 1'b0;
          cnt_d         = 32'd0;
          state_d       = START;
        end else if (cnt_q == 32'(SHOW_CYCLES - 1)) begin
          cnt_d   = 32'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mlp_start_d    = (state_d == START);
    result_valid_d = (state_d == SHOW);
    busy_d         = (state_d == START) || (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 32'd0;
      mlp_grid_q     <= 16'd0;
      mlp_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mlp_grid_q     <= mlp_grid_d;
      mlp_start_q    <= mlp_start_d;
      result_valid_q <= result_valid_d;
      result_class_q <= result_class_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.mlp_start    = mlp_start_q;
  assign bus.mlp_grid     = mlp_grid_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_class = result_class_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_infer_sequencer.sv
// Random transaction-level bench for infer_sequencer: expected events carry the cycle
// they must appear in and are matched by a negedge monitor.
module tb_infer_sequencer;
  localparam int unsigned TO = 8;
  localparam int unsigned SC = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  infer_sequencer_if bus();

  infer_sequencer #(.TIMEOUT(TO), .SHOW_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] val;
    int          len;
  } want_t;

  want_t want_start[$];
  want_t want_ovr[$];
  want_t want_res[$];
  want_t want_to[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic want_t mk(input int c, input logic [15:0] v, input int l);
    want_t w;
    w.cyc = c;
    w.val = v;
    w.len = l;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flagFail(input string name);
    vectors++;
    errors++;
    $display("[TB] FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_mlp_start"},    32'(bus.mlp_start),    32'd0);
    checkOutput({tag, "_mlp_grid"},     32'(bus.mlp_grid),     32'd0);
    checkOutput({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    checkOutput({tag, "_result_class"}, 32'(bus.result_class), 32'd0);
    checkOutput({tag, "_busy"},         32'(bus.busy),         32'd0);
    checkOutput({tag, "_timeout_err"},  32'(bus.timeout_err),  32'd0);
    checkOutput({tag, "_overrun"},      32'(bus.overrun),      32'd0);
  endtask

  // Monitor: every DUT event must match the oldest expectation of its kind.
  logic  prev_rv  = 1'b0;
  logic  prev_to  = 1'b0;
  bit    res_open = 1'b0;
  int    rv_len   = 0;
  want_t cur_res;
  want_t w;

  always @(negedge clk) begin
    if (!rst) begin
      prev_rv  = 1'b0;
      prev_to  = 1'b0;
      res_open = 1'b0;
    end else begin
      if (bus.mlp_start) begin
        if (want_start.size() == 0) flagFail("unexpected_mlp_start");
        else begin
          w = want_start.pop_front();
          checkOutput("start_cycle", 32'(cyc), 32'(w.cyc));
          checkOutput("mlp_grid", 32'(bus.mlp_grid), 32'(w.val));
          checkOutput("busy_in_start", 32'(bus.busy), 32'd1);
          checkOutput("timeout_err_cleared", 32'(bus.timeout_err), 32'd0);
        end
      end
      if (bus.overrun) begin
        if (want_ovr.size() == 0) flagFail("unexpected_overrun");
        else begin
          w = want_ovr.pop_front();
          checkOutput("overrun_cycle", 32'(cyc), 32'(w.cyc));
          checkOutput("grid_kept_on_overrun", 32'(bus.mlp_grid), 32'(w.val));
        end
      end
      if (bus.result_valid && !prev_rv) begin
        rv_len = 0;
        if (want_res.size() == 0) flagFail("unexpected_result_valid");
        else begin
          cur_res  = want_res.pop_front();
          res_open = 1'b1;
          checkOutput("result_cycle", 32'(cyc), 32'(cur_res.cyc));
        end
      end
      if (bus.result_valid) begin
        rv_len++;
        checkOutput("busy_in_show", 32'(bus.busy), 32'd0);
        if (res_open) checkOutput("result_class", 32'(bus.result_class), 32'(cur_res.val));
      end
      if (!bus.result_valid && prev_rv && res_open) begin
        checkOutput("show_length", 32'(rv_len), 32'(cur_res.len));
        res_open = 1'b0;
      end
      if (bus.timeout_err && !prev_to) begin
        if (want_to.size() == 0) flagFail("unexpected_timeout");
        else begin
          w = want_to.pop_front();
          checkOutput("timeout_cycle", 32'(cyc), 32'(w.cyc));
          checkOutput("no_result_on_timeout", 32'(bus.result_valid), 32'd0);
        end
      end
      prev_rv = bus.result_valid;
      prev_to = bus.timeout_err;
    end
  end

  task automatic drive(input logic gv, input logic [15:0] gi, input logic md, input logic mc);
    bus.grid_valid = gv;
    bus.grid_in    = gi;
    bus.mlp_done   = md;
    bus.mlp_class  = mc;
    @(posedge clk);
    #1;
    bus.grid_valid = 1'b0;
    bus.grid_in    = 16'h0;
    bus.mlp_done   = 1'b0;
    bus.mlp_class  = 1'b0;
  endtask

  // One inference: offset 0 is the mlp_start cycle, mlp_done arrives at offset k
  // (k > TO means never), ov_off drops a grid, abort_j cuts the display short.
  task automatic applyStimulus(input logic [15:0] g, input bit do_accept, input int k,
                               input logic c, input int ov_off, input logic [15:0] ov_grid,
                               input int abort_j, input logic [15:0] g2, output bit aborted);
    int  last;
    int  len;
    bit  timed_out;
    aborted   = 1'b0;
    timed_out = (k < 1) || (k > int'(TO));
    last      = timed_out ? int'(TO) : k;
    if (do_accept) begin
      want_start.push_back(mk(cyc + 1, g, 0));
      drive(1'b1, g, 1'b0, 1'b0);
    end
    for (int t = 0; t <= last; t++) begin
      logic gv;
      gv = (t == ov_off);
      if (gv) want_ovr.push_back(mk(cyc + 1, g, 0));
      drive(gv, gv ? ov_grid : 16'h0,
            (t == k) || (t == 0 && $urandom_range(0, 1) == 1),
            (t == k) ? c : 1'($urandom_range(0, 1)));
    end
    if (timed_out) begin
      want_to.push_back(mk(cyc, 16'h0, 0));
    end else begin
      len = (abort_j >= 0 && abort_j < int'(SC)) ? abort_j + 1 : int'(SC);
      want_res.push_back(mk(cyc, {15'd0, c}, len));
      for (int i = 0; i < len; i++) begin
        if (i == abort_j) begin
          want_start.push_back(mk(cyc + 1, g2, 0));
          drive(1'b1, g2, 1'b0, 1'b0);
          aborted = 1'b1;
        end else begin
          drive(1'b0, 16'h0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end
      end
    end
  endtask

  initial begin
    bit          ab;
    bit          first;
    logic [15:0] g;
    logic [15:0] g2;
    int          k;
    int          last;
    int          ov_off;
    int          abort_j;

    bus.grid_valid = 1'b0;
    bus.grid_in    = 16'h0;
    bus.mlp_done   = 1'b0;
    bus.mlp_class  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    $display("[TB] reset released, directed cases");
    rst = 1'b1;

    applyStimulus(16'h9009, 1'b1, 5, 1'b1, -1, 16'h0, -1, 16'h0, ab);
    checkOutput("busy_after_show", 32'(bus.busy), 32'd0);
    checkOutput("rv_after_show", 32'(bus.result_valid), 32'd0);

    applyStimulus(16'h1234, 1'b1, TO + 1, 1'b0, -1, 16'h0, -1, 16'h0, ab);
    checkOutput("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
    checkOutput("busy_after_timeout", 32'(bus.busy), 32'd0);
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    applyStimulus(16'h00F0, 1'b1, TO, 1'b0, -1, 16'h0, -1, 16'h0, ab);

    drive(1'b1, 16'h0, 1'b0, 1'b0);
    checkOutput("zero_grid_no_start", 32'(bus.mlp_start), 32'd0);
    checkOutput("zero_grid_no_busy", 32'(bus.busy), 32'd0);
    checkOutput("zero_grid_no_overrun", 32'(bus.overrun), 32'd0);

    applyStimulus(16'hA5A5, 1'b1, 3, 1'b0, 1, 16'h0660, -1, 16'h0, ab);
    applyStimulus(16'h3C3C, 1'b1, 2, 1'b1, -1, 16'h0, 2, 16'h0660, ab);
    applyStimulus(16'h0660, 1'b0, 4, 1'b0, -1, 16'h0, -1, 16'h0, ab);

    want_start.push_back(mk(cyc + 1, 16'h4242, 0));
    drive(1'b1, 16'h4242, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkReset("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    checkReset("post_reset_done");

    $display("[TB] random transactions");
    repeat (150) begin
      g = 16'($urandom_range(1, 65535));
      repeat ($urandom_range(0, 2))
        drive(1'b0, 16'h0, $urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) drive(1'b1, 16'h0, 1'b0, 1'b0);
      first = 1'b1;
      do begin
        k       = $urandom_range(1, TO + 2);
        last    = (k <= int'(TO)) ? k : int'(TO);
        ov_off  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, last)) : -1;
        abort_j = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, SC - 1)) : -1;
        g2      = 16'($urandom_range(1, 65535));
        applyStimulus(g, first, k, 1'($urandom_range(0, 1)), ov_off,
                      16'($urandom_range(1, 65535)), abort_j, g2, ab);
        first = 1'b0;
        g     = g2;
      end while (ab);
    end

    repeat (3) drive(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("pending_starts", 32'(want_start.size()), 32'd0);
    checkOutput("pending_overruns", 32'(want_ovr.size()), 32'd0);
    checkOutput("pending_results", 32'(want_res.size()), 32'd0);
    checkOutput("pending_timeouts", 32'(want_to.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/infer_sequencer.md
INFER_SEQUENCER -- requirements
Module: infer_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 1024, maximum cycles spent in WAIT for mlp_done; legal range 2..2^32-1.
REQ-002 Parameter SHOW_CYCLES, default 1000, cycles result_valid is held; legal range 1..2^32-1.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 grid_valid  input  1  one-cycle pulse: submitted 4x4 grid available on grid_in.
REQ-006 grid_in  input  16  submitted grid, one bit per cell.
REQ-007 mlp_start  output  1  one-cycle pulse starting one MLP inference.
REQ-008 mlp_grid  output  16  registered operand presented to the MLP, stable from mlp_start until next accept.
REQ-009 mlp_done  input  1  one-cycle pulse: MLP result valid on mlp_class.
REQ-010 mlp_class  input  1  MLP result, 0 = O, 1 = X.
REQ-011 result_valid  output  1  level, high while a result is displayed.
REQ-012 result_class  output  1  latched MLP result.
REQ-013 busy  output  1  high in START and WAIT.
REQ-014 timeout_err  output  1  sticky, set on WAIT timeout.
REQ-015 overrun  output  1  one-cycle pulse, a grid_valid was dropped.

Function
REQ-016 The block SHALL implement a four-state FSM: IDLE, START, WAIT, SHOW; all outputs registered.
REQ-017 IDLE: grid_valid=1 with grid_in!=0 SHALL latch mlp_grid<=grid_in, clear timeout_err, and enter START next cycle.
REQ-018 IDLE: grid_valid=1 with grid_in==0 SHALL be ignored; no state change, no overrun.
REQ-019 START: mlp_start SHALL be 1 for exactly this one cycle; the wait counter is cleared to 0; next state WAIT.
REQ-020 Latency: grid_valid in cycle N SHALL yield mlp_start high in cycle N+1.
REQ-021 WAIT: mlp_done=1 SHALL latch result_class<=mlp_class and enter SHOW; result_valid high from the next cycle.
REQ-022 WAIT: the counter SHALL increment each cycle without mlp_done; at count TIMEOUT-1 without mlp_done, timeout_err<=1, state<=IDLE, result_class unchanged.
REQ-023 mlp_done=1 on the same cycle as the timeout count SHALL take priority: result accepted, no timeout.
REQ-024 mlp_done in IDLE, START or SHOW SHALL be ignored.
REQ-025 SHOW: result_valid=1 for exactly SHOW_CYCLES cycles, then IDLE with result_valid=0.
REQ-026 SHOW: non-zero grid_valid SHALL abort display: result_valid<=0, mlp_grid latched, timeout_err cleared, next state START (same timing as REQ-020).
REQ-027 grid_valid during START or WAIT SHALL be dropped; overrun pulses high the following cycle; mlp_grid unchanged.
REQ-028 busy SHALL be 1 exactly when state is START or WAIT.
REQ-029 Counters SHALL be 32 bits, never wrap: saturation is prevented by the exit conditions above.

Reset
REQ-030 rst low SHALL asynchronously force state IDLE, counters 0, mlp_start 0, mlp_grid 0, result_valid 0, result_class 0, busy 0, timeout_err 0, overrun 0.
REQ-031 Reset asserted mid-WAIT SHALL abandon the inference; a later mlp_done after reset release in IDLE is ignored.
REQ-032 After rst release, the first grid_valid SHALL be accepted on the first rising edge with rst high.

Verification
REQ-033 grid_in=16'h9009 pulse, mlp_done with mlp_class=1 five cycles after mlp_start -> mlp_start one cycle at N+1, mlp_grid=16'h9009, result_valid high SHOW_CYCLES cycles, result_class=1, busy low afterwards.
REQ-034 TIMEOUT=8, no mlp_done -> after 8 WAIT cycles timeout_err=1, state IDLE, result_valid never high; next accepted grid clears timeout_err.
REQ-035 grid_valid with grid_in=0 in IDLE -> no mlp_start, no overrun, busy stays 0.
REQ-036 Second grid_valid (16'h0660) two cycles after first accept -> overrun pulse one cycle, mlp_grid stays first value, single mlp_start.
REQ-037 During SHOW, grid_valid with 16'h0660 -> result_valid falls next cycle, mlp_start pulses, mlp_grid=16'h0660.
REQ-038 rst low during WAIT, then mlp_done after release -> all outputs at reset values, no result_valid.
